// File: rtl/adc_pkg.sv
// Shared constants and state encoding for the ADC SPI responder and the adc master.
package adc_pkg;

    localparam int         ADDR_W          = 3;
    localparam logic [4:0] FRAME_BITS      = 5'd16;
    localparam logic [4:0] LEAD_ZEROS      = 5'd4;
    localparam logic [4:0] ADDR_FIRST_RISE = 5'd3;
    localparam logic [4:0] ADDR_LAST_RISE  = ADDR_FIRST_RISE + 5'(ADDR_W) - 5'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } adc_state_e;

    // True for the sclk rises (1-based) that carry address bits.
    function automatic logic in_addr_window(input logic [4:0] rise_n);
        return (rise_n >= ADDR_FIRST_RISE) && (rise_n <= ADDR_LAST_RISE);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an idle-high bus line plus one extra flop for edge detection.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Next values: shift the raw line in, remember the previous synchronized level.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Chain resets to the idle-high level so no edge is seen coming out of reset on an idle bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/adc_spi_responder.sv
// ADC128S022-style responder: decodes the channel address from the master and
// shifts out the sample of the channel addressed in the previous frame.
module adc_spi_responder
    import adc_pkg::*;
#(
    parameter int NCH         = 8,
    parameter int DW          = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic              adc_cs_n,
    input  logic              adc_sclk,
    input  logic              adc_din,
    output logic              adc_dout,
    input  logic [NCH*DW-1:0] chan_data,
    output logic [2:0]        conv_ch,
    output logic [2:0]        next_ch,
    output logic              frame_done,
    output logic              frame_abort
);

    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES + 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;

    adc_state_e        state_q, state_d;
    logic [4:0]        rise_cnt_q, rise_cnt_d;
    logic [4:0]        fall_cnt_q, fall_cnt_d;
    logic [DW-1:0]     shreg_q, shreg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dout_q, dout_d;
    logic [2:0]        conv_ch_q, conv_ch_d;
    logic [2:0]        next_ch_q, next_ch_d;
    logic              done_q, done_d;
    logic              abort_q, abort_d;
    logic [WARM_W-1:0] warm_cnt_q, warm_cnt_d;
    logic              armed_q, armed_d;
    logic              warm_done_s;
    logic [DW-1:0]     sel_data_s;
    logic [ADDR_W-1:0] addr_next_s;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk_50mhz), .rst(rst), .d(adc_cs_n),
        .q(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk_50mhz), .rst(rst), .d(adc_sclk),
        .q(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign warm_done_s = (warm_cnt_q == WARM_LAST);
    assign sel_data_s  = chan_data[32'(next_ch_q) * DW +: DW];
    assign addr_next_s = {addr_q[ADDR_W-2:0], din_sync_q[SYNC_STAGES-1]};

    // Frame sequencing. After reset the responder only arms once it has seen an
    // idle bus through freshly filled synchronizers, so a reset in the middle of a
    // frame cannot restart on the stale chip-select fall it would otherwise detect.
    always_comb begin
        din_sync_d = {din_sync_q[SYNC_STAGES-2:0], adc_din};
        warm_cnt_d = warm_done_s ? warm_cnt_q : warm_cnt_q + 1'b1;
        armed_d    = armed_q | (warm_done_s & cs_lvl & sclk_lvl & ~cs_rise & ~sclk_rise);
        state_d    = state_q;
        rise_cnt_d = rise_cnt_q;
        fall_cnt_d = fall_cnt_q;
        shreg_d    = shreg_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        conv_ch_d  = conv_ch_q;
        next_ch_d  = next_ch_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                if (armed_q && cs_fall) begin
                    conv_ch_d  = next_ch_q;
                    shreg_d    = sel_data_s;
                    rise_cnt_d = 5'd0;
                    fall_cnt_d = 5'd0;
                    addr_d     = '0;
                    state_d    = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort_d    = 1'b1;
                    rise_cnt_d = 5'd0;
                    fall_cnt_d = 5'd0;
                    dout_d     = 1'b0;
                    state_d    = IDLE;
                end else if (sclk_rise) begin
                    rise_cnt_d = rise_cnt_q + 5'd1;
                    if (in_addr_window(rise_cnt_d)) begin
                        addr_d = addr_next_s;
                    end else begin
                        addr_d = addr_q;
                    end
                    if (rise_cnt_d == ADDR_LAST_RISE) begin
                        next_ch_d = 3'(addr_next_s);
                    end else begin
                        next_ch_d = next_ch_q;
                    end
                    if (rise_cnt_d == FRAME_BITS) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end else if (sclk_fall) begin
                    fall_cnt_d = fall_cnt_q + 5'd1;
                    if (fall_cnt_d < LEAD_ZEROS) begin
                        dout_d = 1'b0;
                    end else if (fall_cnt_d < FRAME_BITS) begin
                        dout_d  = shreg_q[DW-1];
                        shreg_d = {shreg_q[DW-2:0], 1'b0};
                    end else begin
                        dout_d = dout_q;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    rise_cnt_d = 5'd0;
                    fall_cnt_d = 5'd0;
                    dout_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                dout_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // All responder state, with synchronous reset to the idle values.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            din_sync_q <= '1;
            warm_cnt_q <= '0;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
            rise_cnt_q <= 5'd0;
            fall_cnt_q <= 5'd0;
            shreg_q    <= '0;
            addr_q     <= '0;
            dout_q     <= 1'b0;
            conv_ch_q  <= 3'd0;
            next_ch_q  <= 3'd0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            din_sync_q <= din_sync_d;
            warm_cnt_q <= warm_cnt_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
            rise_cnt_q <= rise_cnt_d;
            fall_cnt_q <= fall_cnt_d;
            shreg_q    <= shreg_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            conv_ch_q  <= conv_ch_d;
            next_ch_q  <= next_ch_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
        end
    end

    assign adc_dout    = dout_q;
    assign conv_ch     = conv_ch_q;
    assign next_ch     = next_ch_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable 3-wire SPI ADC responder. It emulates an 8-channel, 12-bit ADC128S022-style converter from the bus side.
- Sits opposite the existing adc master on adc_cs_n/adc_sclk/adc_din/adc_dout, so the master can be exercised in loopback on the board and in simulation without a real converter.
- Oversamples the bus with the system clock, decodes the channel address shifted in by the master, and shifts out the 12-bit value of the channel selected in the previous frame.

Parameters:
- NCH, 8, number of channels (address width fixed at 3 bits).
- DW, 12, sample width.
- SYNC_STAGES, 2, synchronizer depth on adc_cs_n, adc_sclk and adc_din (minimum 2).

Ports:
- clk_50mhz  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- adc_cs_n  input  1  chip select from master, active low.
- adc_sclk  input  1  serial clock from master, idle high.
- adc_din  input  1  address/control bits from master, sampled on sclk rising edges.
- adc_dout  output  1  serial data to master, MSB first.
- chan_data  input  NCH*DW  flattened channel values; channel k occupies bits [k*DW +: DW].
- conv_ch  output  3  channel whose data is being or was last shifted out.
- next_ch  output  3  channel address decoded from the current or last frame.
- frame_done  output  1  one-cycle pulse when a full 16-bit frame completes.
- frame_abort  output  1  one-cycle pulse when cs_n rises before 16 rising edges.

Behaviour:
- Reset values: adc_dout=0, conv_ch=0, next_ch=0, frame_done=0, frame_abort=0, state=IDLE, bit counter=0, synchronizer flops=1 (cs_n and sclk idle high).
- Inputs pass through SYNC_STAGES flops. One more registered copy provides edge detection: sclk rise, sclk fall, cs fall, cs rise.
- Latency: a bus edge is acted on SYNC_STAGES+1 clocks after it occurs. Supported sclk half-period is at least SYNC_STAGES+2 clocks, i.e. master div_param of 4 or more.
- FSM IDLE:
  - adc_dout=0.
  - On cs fall: conv_ch<=next_ch; shift register<=chan_data[next_ch], captured in that cycle; rise counter<=0; adc_dout<=0 (leading zero 1); go to SHIFT.
- FSM SHIFT:
  - On sclk rise: rise counter increments. At rises 3, 4 and 5 (1-based), adc_din is shifted into addr bits 2, 1 and 0. At rise 5 the full address is written to next_ch.
  - On sclk fall: the fall counter selects the next output bit. Falls 1-3 drive zeros 2-4. Falls 4-15 drive sample bits DW-1 down to 0.
  - After rise 16: frame_done pulses once; go to DONE.
- FSM DONE:
  - adc_dout holds bit 0.
  - Further sclk edges are ignored until cs rise; then go to IDLE with adc_dout=0.
- cs rise while in SHIFT (abort):
  - frame_abort pulses once; return to IDLE; counters cleared.
  - next_ch keeps its new value only if rise 5 had already occurred; otherwise it keeps the old value.
- Simultaneous cs rise and sclk edge in the same cycle: cs rise wins and the sclk edge is discarded.
- cs fall in the same cycle as an sclk edge: the frame starts and the sclk edge is ignored.
- More than 16 rises within one cs-low window: extra rises are ignored (DONE state).
- chan_data may change at any time. Only the value captured at cs fall is shifted; mid-frame changes have no effect.
- rst asserted mid-frame: all state returns to reset values on the next clock. The bus frame is lost and no done/abort pulse is produced.
- frame_done and frame_abort are never high in the same cycle.

Decomposition:
- Shared package adc_pkg: ADDR_W=3, FRAME_BITS=16, LEAD_ZEROS=4, ADDR_FIRST_RISE=3, and state encodings IDLE/SHIFT/DONE.
- One sub-module is natural: sync_edge_det (SYNC_STAGES-deep synchronizer plus rise/fall outputs). It is instantiated once each for cs_n and sclk; din uses the synchronizer only.
- The master adc should import the same adc_pkg constants.

Test Plan:
- Reset, then chan_data ch0=0x123, ch5=0xABC. Frame 1 with din address 5 at rises 3-5 -> dout bits = 0000_0001_0010_0011 (ch0, next_ch reset value); next_ch=5 after rise 5; frame_done pulses once. Frame 2 -> dout = 0000_1010_1011_1100, conv_ch=5.
- Connect the adc master (channel=5, div_param=13, en pulse) back-to-back with chan_data ch5=0x5A5 -> master adc_data=0x5A5 on the second conversion and adc_done asserted; responder frame_done count = master conversion count.
- cs rises after 4 sclk rises -> frame_abort pulses, next_ch unchanged. cs rises after 7 rises (address 3) -> frame_abort pulses, next_ch=3; the next full frame shifts ch3.
- chan_data[ch] changed from 0xFFF to 0x000 mid-frame after cs fall -> dout still shifts 0xFFF; the following frame shifts 0x000.
- 20 sclk cycles inside one cs-low window -> exactly one frame_done; dout holds bit 0 after the 16th edge; next frame is unaffected.
- rst pulsed high for 1 clock at rise 9 -> adc_dout=0, next_ch=0, no done/abort pulse. After cs cycles high, a fresh frame behaves as in the first scenario.
